avalon_seg_writer_master: RTL and testbench
===========================================

Name: avalon_seg_writer_master

Overview:
Avalon-MM write master that drives the 7-segment register slave on DE1-SoC. It accepts a packed hex value on a valid/ready input and issues one single-word write per digit to addresses 0..NUM_SEGMENT-1. It honours waitrequest and can optionally skip digits whose value has not changed. It sits between a value producer (counter, CPU-less test logic) and the segment slave in the Platform Designer fabric.

Parameters:
NUM_SEGMENT, 6, number of digits/addresses written per update (1..8; elaboration error outside range)
SKIP_UNCHANGED, 0, 1 = do not re-write digits equal to the last value written

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
value_i  input  NUM_SEGMENT*4  packed hex digits; digit k = value_i[4k+3:4k]
value_valid_i  input  1  value_i valid
value_ready_o  output  1  block can accept a new value
avm_address_o  output  3  word address = digit index
avm_byteenable_o  output  4  byte enables
avm_write_o  output  1  write request
avm_writedata_o  output  32  write data
avm_waitrequest_i  input  1  slave stall
busy_o  output  1  update sequence in progress
done_o  output  1  one-cycle pulse after the last digit is processed

Behaviour:
- Reset (async assert, sync release): state IDLE; value_ready_o=1; avm_write_o=0; avm_address_o=0; avm_byteenable_o=0; avm_writedata_o=0; busy_o=0; done_o=0; shadow and last-written registers cleared; written_valid=0.
- All outputs are registered. No combinational path from avm_waitrequest_i or value_valid_i to any output.
- FSM states: IDLE, WRITE, DONE.
- IDLE: value_ready_o=1. On value_valid_i & value_ready_o, latch value_i into shadow, idx=0, enter WRITE next cycle. value_ready_o=0 from that cycle until return to IDLE.
- WRITE, digit idx needs writing: avm_write_o=1, avm_address_o=idx, avm_byteenable_o=4'b0001, avm_writedata_o={28'b0, shadow digit idx}.
  - While avm_waitrequest_i=1: all avm_* outputs held stable.
  - Acceptance = avm_write_o & !avm_waitrequest_i.
  - On acceptance: last_written[idx] = digit. If idx==NUM_SEGMENT-1, go to DONE. Otherwise idx+1, and avm_write_o stays 1 (back-to-back, one write per cycle with no stall).
- WRITE, SKIP_UNCHANGED=1 and written_valid=1 and digit idx == last_written[idx]: the cycle presenting idx has avm_write_o=0 and advances idx (or goes to DONE if last). Skipped digits cost one cycle each.
- DONE: one cycle. done_o=1, written_valid=1, busy_o=0 next cycle, then return to IDLE.
- busy_o=1 in WRITE and DONE.
- Latency, no waitrequest, nothing skipped: handshake at cycle 0; writes at cycles 1..NUM_SEGMENT; done_o at cycle NUM_SEGMENT+1; value_ready_o=1 at cycle NUM_SEGMENT+2.
- First update after reset always writes all digits, since written_valid=0.
- value_valid_i while busy: ignored, not latched. The producer holds the value (standard valid/ready).
- Reset mid-sequence: the write is aborted immediately (avm_write_o=0). This is acceptable only under reset. written_valid is cleared, so the next update rewrites everything.
- Upper 28 bits of writedata are always 0. byteenable is never other than 0001 or 0000.

Decomposition:
- Shared package seg_avalon_pkg: state enum (IDLE/WRITE/DONE), the 3-bit address width constant, the digit width constant (4), and BYTEEN_DIGIT = 4'b0001.
- No sub-module required. The FSM and per-digit shadow/last-written registers fit in one module.

Test Plan:
1. NUM_SEGMENT=6, value 24'h123456, waitrequest=0 -> writes addr0..5 with data 6,5,4,3,2,1 on consecutive cycles, byteenable=0001; done_o pulses at cycle 7.
2. waitrequest held high 3 cycles on addr2 -> addr/data/write stable for 4 cycles; single acceptance; all 6 writes complete; done_o once.
3. SKIP_UNCHANGED=1: send 24'h000000 then 24'h0000A0 -> second update produces exactly one write (addr1, data 0xA); done_o at cycle 7.
4. value_valid_i asserted with 24'hFFFFFF during a busy sequence -> not latched. It is accepted only after value_ready_o returns high, and then produces 6 writes of 0xF.
5. rst_n asserted during the addr3 write -> avm_write_o drops asynchronously and all outputs reach reset values. After release, value 24'h111111 with SKIP_UNCHANGED=1 yields all 6 writes.
6. Slave model scoreboard compares final register contents against the last value sent, over 200 random values with random waitrequest.

Source files
------------

// File: rtl/seg_avalon_pkg.sv
// Shared types and constants for the Avalon-MM 7-segment writer master.
// The FSM state encoding and the fixed bus field widths live here.
package seg_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int          ADDR_W       = 3;
  localparam int          DIGIT_W      = 4;
  localparam int          DATA_W       = 32;
  localparam int          BE_W         = 4;
  localparam logic [3:0]  BYTEEN_DIGIT = 4'b0001;

endpackage : seg_avalon_pkg

// File: rtl/avalon_seg_writer_master.sv
// Avalon-MM write master: takes a packed hex value on valid/ready and writes one
// digit per word address to the segment slave, optionally skipping unchanged digits.
module avalon_seg_writer_master
  import seg_avalon_pkg::*;
#(
  parameter int NUM_SEGMENT    = 6,
  parameter bit SKIP_UNCHANGED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SEGMENT*4-1:0]     value_i,
  input  logic                         value_valid_i,
  output logic                         value_ready_o,
  output logic [ADDR_W-1:0]            avm_address_o,
  output logic [BE_W-1:0]              avm_byteenable_o,
  output logic                         avm_write_o,
  output logic [DATA_W-1:0]            avm_writedata_o,
  input  logic                         avm_waitrequest_i,
  output logic                         busy_o,
  output logic                         done_o
);

  if (NUM_SEGMENT < 1 || NUM_SEGMENT > 8) begin : g_bad_num_segment
    $error("avalon_seg_writer_master: NUM_SEGMENT must be in 1..8");
  end

  localparam int                VAL_W    = NUM_SEGMENT * DIGIT_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SEGMENT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]    shadow_q, shadow_d;
  logic [VAL_W-1:0]    last_q, last_d;
  logic                written_valid_q, written_valid_d;
  logic                ready_q, ready_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Selects which digit the bus presents next cycle and where it is read from.
  logic                present;
  logic [ADDR_W-1:0]   pres_idx;
  logic [VAL_W-1:0]    pres_src;
  logic [DIGIT_W-1:0]  pres_digit;
  logic [DIGIT_W-1:0]  pres_prev;

  function automatic logic needs_write(input logic [DIGIT_W-1:0] digit,
                                       input logic [DIGIT_W-1:0] prev,
                                       input logic               wvalid);
    return !(SKIP_UNCHANGED && wvalid && (digit == prev));
  endfunction

  // NOTE: every always_comb output gets its default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    shadow_d        = shadow_q;
    last_d          = last_q;
    written_valid_d = written_valid_q;
    ready_d         = ready_q;
    write_d         = write_q;
    addr_d          = addr_q;
    be_d            = be_q;
    data_d          = data_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    present         = 1'b0;
    pres_idx        = idx_q;
    pres_src        = shadow_q;
    pres_digit      = '0;
    pres_prev       = '0;

    unique case (state_q)
      IDLE: begin
        if (value_valid_i && ready_q) begin
          shadow_d = value_i;
          idx_d    = '0;
          state_d  = WRITE;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          present  = 1'b1;
          pres_idx = '0;
          pres_src = value_i;
        end
      end

      WRITE: begin
        // A stalled write keeps every bus output frozen; anything else retires idx.
        if (!(write_q && avm_waitrequest_i)) begin
          if (write_q) begin
            last_d[DIGIT_W*idx_q +: DIGIT_W] = shadow_q[DIGIT_W*idx_q +: DIGIT_W];
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            write_d = 1'b0;
            addr_d  = '0;
            be_d    = '0;
            data_d  = '0;
          end else begin
            idx_d    = idx_q + 1'b1;
            present  = 1'b1;
            pres_idx = idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d         = IDLE;
        ready_d         = 1'b1;
        busy_d          = 1'b0;
        written_valid_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (present) begin
      pres_digit = pres_src[DIGIT_W*pres_idx +: DIGIT_W];
      pres_prev  = last_q[DIGIT_W*pres_idx +: DIGIT_W];
      write_d    = needs_write(pres_digit, pres_prev, written_valid_q);
      if (write_d) begin
        addr_d = pres_idx;
        be_d   = BYTEEN_DIGIT;
        data_d = {{(DATA_W-DIGIT_W){1'b0}}, pres_digit};
      end else begin
        addr_d = '0;
        be_d   = '0;
        data_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: shadow and last-written registers are reset too; the skip compare reads
  // them, and a cleared state makes the first post-reset update deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      shadow_q        <= '0;
      last_q          <= '0;
      written_valid_q <= 1'b0;
      ready_q         <= 1'b1;
      write_q         <= 1'b0;
      addr_q          <= '0;
      be_q            <= '0;
      data_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      shadow_q        <= shadow_d;
      last_q          <= last_d;
      written_valid_q <= written_valid_d;
      ready_q         <= ready_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      be_q            <= be_d;
      data_q          <= data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign value_ready_o    = ready_q;
  assign avm_write_o      = write_q;
  assign avm_address_o    = addr_q;
  assign avm_byteenable_o = be_q;
  assign avm_writedata_o  = data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule : avalon_seg_writer_master

// File: tb/tb_avalon_seg_writer_master.sv
// Self-checking bench: one plain and one skip-unchanged instance, each driven
// against a digit-list reference model and a slave register scoreboard.
module tb_avalon_seg_writer_master;

  localparam int NSEG = 6;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0 = plain instance, index 1 = skip-unchanged instance.
  logic        rstn   [2];
  logic [23:0] val    [2];
  logic        vld    [2];
  logic        wreq   [2];
  logic        rdy_o  [2];
  logic        wr_o   [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [2:0]  addr_o [2];
  logic [3:0]  be_o   [2];
  logic [31:0] data_o [2];

  avalon_seg_writer_master #(.NUM_SEGMENT(NSEG), .SKIP_UNCHANGED(1'b0)) u_plain (
    .clk(clk), .rst_n(rstn[0]), .value_i(val[0]), .value_valid_i(vld[0]),
    .value_ready_o(rdy_o[0]), .avm_address_o(addr_o[0]), .avm_byteenable_o(be_o[0]),
    .avm_write_o(wr_o[0]), .avm_writedata_o(data_o[0]), .avm_waitrequest_i(wreq[0]),
    .busy_o(busy_o[0]), .done_o(done_o[0])
  );

  avalon_seg_writer_master #(.NUM_SEGMENT(NSEG), .SKIP_UNCHANGED(1'b1)) u_skip (
    .clk(clk), .rst_n(rstn[1]), .value_i(val[1]), .value_valid_i(vld[1]),
    .value_ready_o(rdy_o[1]), .avm_address_o(addr_o[1]), .avm_byteenable_o(be_o[1]),
    .avm_write_o(wr_o[1]), .avm_writedata_o(data_o[1]), .avm_waitrequest_i(wreq[1]),
    .busy_o(busy_o[1]), .done_o(done_o[1])
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  mdl_last [2][NSEG];
  bit          mdl_wv   [2];
  logic [31:0] slave    [2][NSEG];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    mdl_wv[d] = 1'b0;
    for (int k = 0; k < NSEG; k++) mdl_last[d][k] = 4'h0;
  endtask

  task automatic check_idle(input int d, input string tag);
    check($sformatf("%s_write_d%0d", tag, d), wr_o[d], 0);
    check($sformatf("%s_addr_d%0d", tag, d), addr_o[d], 0);
    check($sformatf("%s_be_d%0d", tag, d), be_o[d], 0);
    check($sformatf("%s_data_d%0d", tag, d), data_o[d], 0);
    check($sformatf("%s_busy_d%0d", tag, d), busy_o[d], 0);
    check($sformatf("%s_done_d%0d", tag, d), done_o[d], 0);
    check($sformatf("%s_ready_d%0d", tag, d), rdy_o[d], 1);
  endtask

  // stall_mode: 0 none, 1 hold waitrequest stall_len cycles on stall_addr, 2 random.
  // poke: producer presents 24'hFFFFFF with valid high while the update is busy.
  // abort_addr >= 0: pulse reset while that address is being presented.
  task automatic do_update(input int d, input logic [23:0] v, input int stall_mode,
                           input int stall_addr, input int stall_len, input bit poke,
                           input int abort_addr, input int exp_hs_wait);
    logic [2:0]  exp_a[$];
    logic [31:0] exp_dt[$];
    logic [2:0]  obs_a[$];
    logic [31:0] obs_dt[$];
    logic [3:0]  dg;
    int          hs, c, stalls, stall_cnt, flag_bad;
    bit          w, prev_stall, aborted;
    logic [2:0]  p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_be;

    for (int k = 0; k < NSEG; k++) begin
      dg = v[4*k +: 4];
      if (d == 0 || !mdl_wv[d] || dg != mdl_last[d][k]) begin
        exp_a.push_back(3'(k));
        exp_dt.push_back({28'h0, dg});
      end
    end

    hs = 0;
    @(negedge clk);
    val[d] = v;
    vld[d] = 1'b1;
    while (!rdy_o[d] && hs < 50) begin
      @(negedge clk);
      hs++;
    end
    check($sformatf("hs_ready_d%0d", d), rdy_o[d], 1);
    if (!rdy_o[d]) begin
      vld[d] = 1'b0;
      return;
    end
    if (exp_hs_wait >= 0) check($sformatf("hs_wait_d%0d", d), hs, exp_hs_wait);

    @(negedge clk);
    c = 1; stalls = 0; stall_cnt = 0; flag_bad = 0; prev_stall = 1'b0; aborted = 1'b0;
    p_addr = '0; p_data = '0; p_be = '0;
    if (poke) begin
      val[d] = 24'hFFFFFF;
      vld[d] = 1'b1;
    end else begin
      vld[d] = 1'b0;
    end

    while (c < 64) begin
      if (done_o[d]) break;
      if (abort_addr >= 0 && wr_o[d] && addr_o[d] == 3'(abort_addr)) begin
        rstn[d] = 1'b0;
        vld[d]  = 1'b0;
        wreq[d] = 1'b0;
        #1;
        check_idle(d, "async_rst");
        @(negedge clk);
        rstn[d] = 1'b1;
        model_reset(d);
        aborted = 1'b1;
        break;
      end
      if (!busy_o[d] || rdy_o[d]) flag_bad++;
      if (wr_o[d] ? (be_o[d] != 4'b0001) : (be_o[d] != 4'b0000)) flag_bad++;
      if (prev_stall) begin
        check($sformatf("stall_write_d%0d", d), wr_o[d], 1);
        check($sformatf("stall_addr_d%0d", d), addr_o[d], p_addr);
        check($sformatf("stall_data_d%0d", d), data_o[d], p_data);
        check($sformatf("stall_be_d%0d", d), be_o[d], p_be);
      end
      case (stall_mode)
        1:       w = wr_o[d] && addr_o[d] == 3'(stall_addr) && stall_cnt < stall_len;
        2:       w = ($urandom_range(0, 99) < 30);
        default: w = 1'b0;
      endcase
      if (w && wr_o[d]) stall_cnt++;
      wreq[d] = w;
      if (wr_o[d]) begin
        if (w) begin
          stalls++;
        end else begin
          obs_a.push_back(addr_o[d]);
          obs_dt.push_back(data_o[d]);
          if (addr_o[d] < 3'(NSEG)) slave[d][addr_o[d]] = data_o[d];
        end
      end
      prev_stall = wr_o[d] && w;
      p_addr = addr_o[d];
      p_data = data_o[d];
      p_be   = be_o[d];
      @(negedge clk);
      c++;
    end
    wreq[d] = 1'b0;
    if (aborted) return;

    check($sformatf("done_seen_d%0d", d), done_o[d], 1);
    check($sformatf("done_cycle_d%0d", d), c, NSEG + 1 + stalls);
    check($sformatf("busy_in_done_d%0d", d), busy_o[d], 1);
    check($sformatf("ready_in_done_d%0d", d), rdy_o[d], 0);
    check($sformatf("protocol_flags_d%0d", d), flag_bad, 0);
    check($sformatf("n_writes_d%0d", d), obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      check($sformatf("wr%0d_addr_d%0d", i, d), obs_a[i], exp_a[i]);
      check($sformatf("wr%0d_data_d%0d", i, d), obs_dt[i], exp_dt[i]);
    end
    for (int k = 0; k < NSEG; k++) begin
      check($sformatf("slave_reg%0d_d%0d", k, d), slave[d][k], {28'h0, v[4*k +: 4]});
      mdl_last[d][k] = v[4*k +: 4];
    end
    mdl_wv[d] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] prev [2];
    logic [23:0] nv;
    int          d;

    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; vld[i] = 1'b0; wreq[i] = 1'b0; val[i] = '0;
      model_reset(i);
      for (int k = 0; k < NSEG; k++) slave[i][k] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle(0, "in_reset");
    check_idle(1, "in_reset");
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    @(negedge clk);
    check_idle(0, "post_reset");
    check_idle(1, "post_reset");

    // Plain instance: straight update, stalled update, then a value offered while busy.
    do_update(0, 24'h123456, 0, 0, 0, 1'b0, -1, 0);
    do_update(0, 24'h654321, 1, 2, 3, 1'b0, -1, 0);
    do_update(0, 24'hABCDEF, 0, 0, 0, 1'b1, -1, 0);
    do_update(0, 24'hFFFFFF, 0, 0, 0, 1'b0, -1, 0);

    // Skip instance: single changed digit, then a reset-aborted update.
    do_update(1, 24'h000000, 0, 0, 0, 1'b0, -1, 0);
    do_update(1, 24'h0000A0, 0, 0, 0, 1'b0, -1, 0);
    do_update(1, 24'h111111, 0, 0, 0, 1'b0, -1, 0);
    do_update(1, 24'h222222, 0, 0, 0, 1'b0, 3, 0);
    do_update(1, 24'h111111, 0, 0, 0, 1'b0, -1, 0);

    prev[0] = 24'hFFFFFF;
    prev[1] = 24'h111111;
    for (int i = 0; i < 200; i++) begin
      d  = i % 2;
      nv = prev[d];
      if ($urandom_range(0, 7) == 0) begin
        nv = 24'($urandom());
      end else begin
        for (int k = 0; k < NSEG; k++)
          if ($urandom_range(0, 2) == 0) nv[4*k +: 4] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_update(d, nv, 2, 0, 0, 1'b0, -1, -1);
      prev[d] = nv;
    end

    repeat (2) @(negedge clk);
    check_idle(0, "final");
    check_idle(1, "final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_avalon_seg_writer_master
